// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage feeding control_unit.
//
// Owns the PC and issues requests to instruction memory. It registers each
// fetched word into the IF/ID output register. It handles variable-latency
// memory, a downstream stall through a 1-entry hold buffer, and branch/jump
// redirects. A redirect can arrive while a request is still outstanding.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   defined   -> fetch_count counts the words delivered into the output register
//   undefined -> fetch_count is tied to zero and has no flops
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_req/addr       registered fetch request, held until imem_ack
//   imem_ack/rdata      memory response (data valid with ack)
//   id_stall            downstream hold request for the output register
//   branch_taken/target redirect (has priority over jump)
//   jump/jump_target    redirect
//   if_valid/inst/pc    IF/ID output register
//   if_opcode           if_inst[31:26]
//   if_pc_plus4         if_pc + 4
//   fetch_count         delivered-instruction counter
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              id_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [5:0]        if_opcode,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                imem_req_q, imem_req_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [ADDR_W-1:0]   if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0]         hold_inst_q, hold_inst_d;

  logic                ack;
  logic                redir;
  logic [ADDR_W-1:0]   tgt;
  logic [ADDR_W-1:0]   tgt_al;
  logic [ADDR_W-1:0]   pc_plus4;
  logic                out_free;

  // An ack only counts while a request is actually on the bus.
  assign ack      = imem_ack & imem_req_q;
  assign redir    = branch_taken | jump;
  assign tgt      = branch_taken ? branch_target : jump_target;
  assign tgt_al   = tgt & ~ADDR_W'(3);
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign out_free = !if_valid_q || !id_stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    hold_inst_d   = hold_inst_q;

    case (state_q)
      S_REQ: begin
        if (redir) begin
          // The request cannot be withdrawn. A redirect that arrives without
          // an ack must wait for the response in S_DROP. With no request on
          // the bus (first cycle after reset), retargeting at once is safe.
          if (ack || !imem_req_q) begin
            req_addr_d = tgt_al;
          end else begin
            state_d = S_DROP;
          end
        end else if (ack) begin
          if (out_free) begin
            if_valid_d    = 1'b1;
            if_inst_d     = imem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            pc_d          = pc_plus4;
            req_addr_d    = pc_plus4;
          end else begin
            // pc_q is left unchanged while in S_HOLD, so it still holds the
            // buffered word's address and no separate buffer PC is needed.
            hold_inst_d = imem_rdata;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          req_addr_d = tgt_al;
          state_d    = S_REQ;
        end else if (!id_stall) begin
          if_valid_d    = 1'b1;
          if_inst_d     = hold_inst_q;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_plus4;
          pc_d          = pc_plus4;
          req_addr_d    = pc_plus4;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        // If a fresh redirect coincides with the ack of the stale request,
        // nothing is outstanding any more, so the new target is fetched next.
        if (ack) begin
          req_addr_d = redir ? tgt_al : pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redir) begin
      pc_d       = tgt_al;
      if_valid_d = 1'b0;
      if_inst_d  = '0;
    end

    imem_req_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      imem_req_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      hold_inst_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      imem_req_q    <= imem_req_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      hold_inst_q   <= hold_inst_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        load_out;
  logic [31:0] fetch_count_q;

  assign load_out = !redir &&
                    (((state_q == S_REQ) && ack && out_free) ||
                     ((state_q == S_HOLD) && !id_stall));

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (load_out) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = req_addr_q;
  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_opcode   = if_inst_q[31:26];
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_opcode     (if_opcode),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; id_stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    tick(); tick();

    // Reset state
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h100);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst",  if_inst, 32'd0);
    chk("rst_pc",    if_pc, 32'd0);
    chk("rst_pc4",   if_pc_plus4, 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);

    // Ack while imem_req is still low must be ignored
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
    tick();
    chk("req_rise",  {31'd0, imem_req}, 32'd1);
    chk("ign_ack",   {31'd0, if_valid}, 32'd0);
    chk("addr0",     imem_addr, 32'h100);

    // Back-to-back fetch, ack every cycle
    imem_rdata = 32'h2001_0100;
    tick();
    chk("b2b_addr1", imem_addr, 32'h104);
    chk("b2b_pc0",   if_pc, 32'h100);
    chk("b2b_val",   {31'd0, if_valid}, 32'd1);
    chk("b2b_inst0", if_inst, 32'h2001_0100);
    imem_rdata = 32'h2002_0104;
    tick();
    chk("b2b_addr2", imem_addr, 32'h108);
    chk("b2b_pc1",   if_pc, 32'h104);
    chk("b2b_pc1p4", if_pc_plus4, 32'h108);

    // Stall while the word at 0x108 returns
    id_stall = 1'b1; imem_rdata = 32'h8C22_0004;
    tick();
    chk("hold_req",  {31'd0, imem_req}, 32'd0);
    chk("hold_inst", if_inst, 32'h2002_0104);
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    tick(); tick();
    chk("hold_inst2", if_inst, 32'h2002_0104);
    chk("hold_pc",    if_pc, 32'h104);
    chk("hold_req2",  {31'd0, imem_req}, 32'd0);
    id_stall = 1'b0;
    tick();
    chk("rel_inst", if_inst, 32'h8C22_0004);
    chk("rel_op",   {26'd0, if_opcode}, 32'h23);
    chk("rel_pc",   if_pc, 32'h108);
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h10C);

    // Move to 0x200: redirect with the 0x10C request outstanding
    jump = 1'b1; jump_target = 32'h200;
    tick();
    chk("j_val",   {31'd0, if_valid}, 32'd0);
    chk("j_inst",  if_inst, 32'd0);
    chk("j_addr",  imem_addr, 32'h10C);
    jump = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    chk("issue200", imem_addr, 32'h200);
    chk("drop_val", {31'd0, if_valid}, 32'd0);

    // Branch to 0x403 one cycle after issue, ack three cycles late
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h403;
    tick();
    branch_taken = 1'b0;
    chk("br_hold_addr", imem_addr, 32'h200);
    tick();
    chk("br_hold_req",  {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    chk("br_addr",  imem_addr, 32'h400);
    chk("br_val",   {31'd0, if_valid}, 32'd0);

    // Same-cycle ack and jump to 0x800
    imem_rdata = 32'h3333_3333; jump = 1'b1; jump_target = 32'h800;
    tick();
    chk("jack_addr", imem_addr, 32'h800);
    chk("jack_val",  {31'd0, if_valid}, 32'd0);
    chk("jack_inst", if_inst, 32'd0);

    // Branch (0x300) and jump (0x500) together: branch wins
    branch_taken = 1'b1; branch_target = 32'h300; jump_target = 32'h500;
    imem_rdata = 32'h4444_4444;
    tick();
    chk("prio_addr", imem_addr, 32'h300);
    branch_taken = 1'b0; jump = 1'b0; imem_rdata = 32'h2400_0300;
    tick();
    chk("prio_pc",   if_pc, 32'h300);
    chk("prio_inst", if_inst, 32'h2400_0300);

    // Wrap: redirect to 0xFFFFFFFF (aligned to 0xFFFFFFFC)
    jump = 1'b1; jump_target = 32'hFFFF_FFFF; imem_rdata = 32'h5555_5555;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    jump = 1'b0; imem_rdata = 32'h3C01_FFFF;
    tick();
    chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4",  if_pc_plus4, 32'd0);
    chk("wrap_next", imem_addr, 32'd0);
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'h0800_0000 + 32'(i);
      tick();
    end
    imem_ack = 1'b0;
    chk("post_pc",   if_pc, 32'h10);
    chk("post_pc4",  if_pc_plus4, 32'h14);
    chk("post_inst", if_inst, 32'h0800_0004);
    chk("post_addr", imem_addr, 32'h14);

    // Delivered: 0x100, 0x104, 0x108, 0x300, 0xFFFFFFFC, 0x0..0x10 = 10
`ifdef FETCH_PERF_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    chk("fetch_cnt", fetch_count, exp_cnt);

    rst = 1'b1;
    tick();
    chk("rst2_cnt", fetch_count, 32'd0);
    chk("rst2_val", {31'd0, if_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of control_unit: owns the PC, issues requests to instruction memory, and registers the fetched word into the IF/ID output register.
- if_opcode (bits [31:26]) drives the control_unit inst input.
- Handles variable-latency memory, downstream stall, and branch/jump redirect, including a redirect while a request is outstanding.

Parameters:
ADDR_W, 32, PC / memory address width
RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  ADDR_W  fetch address, stable while imem_req is high
imem_ack  input  1  memory response valid; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
id_stall  input  1  downstream cannot accept; hold output register
branch_taken  input  1  redirect to branch_target
branch_target  input  ADDR_W  branch destination
jump  input  1  redirect to jump_target
jump_target  input  ADDR_W  jump destination
if_valid  output  1  output register holds a live instruction
if_inst  output  32  registered instruction word
if_opcode  output  6  if_inst[31:26], to control_unit
if_pc  output  ADDR_W  address of if_inst
if_pc_plus4  output  ADDR_W  if_pc + 4
fetch_count  output  32  delivered-instruction counter (see Optional Feature)

Behaviour:
- Reset (rst high at posedge, overrides everything):
  - pc = RESET_PC, req_addr = RESET_PC, state = S_REQ.
  - if_valid = 0; if_inst = 0; if_pc = 0; if_pc_plus4 = 0; fetch_count = 0.
  - imem_req = 0 in the cycle after reset; it rises on the following cycle.
  - Any in-flight response is not tracked; imem_ack received while imem_req=0 is ignored.
- imem_req and imem_addr are registered outputs. imem_addr = req_addr.
- States:
  - S_REQ: imem_req = 1. On imem_ack:
    - If the output is free (!if_valid or !id_stall): load if_inst/if_pc/if_pc_plus4, set if_valid = 1, set pc and req_addr to pc+4, stay in S_REQ. Back-to-back fetch gives 1 instruction per cycle when ack is immediate.
    - Otherwise: capture the word and its pc into the 1-entry hold buffer, drop imem_req, go to S_HOLD.
  - S_HOLD: imem_req = 0. When id_stall falls, move the buffer into the output register, set pc and req_addr to pc+4, go to S_REQ.
  - S_DROP: imem_req = 1 at the old req_addr. Wait for imem_ack, discard the data, then set req_addr = pc and go to S_REQ.
- Output hold: while id_stall = 1 and if_valid = 1, the output register is frozen.
- Redirect: branch_taken or jump.
  - branch_taken has priority if both are asserted.
  - Redirect is not blocked by id_stall.
  - Target is taken with low 2 bits forced to 0.
  - Next cycle: pc = target; if_valid = 0; if_inst = 0; hold buffer invalidated.
  - In S_REQ with no imem_ack that cycle → S_DROP; the protocol forbids withdrawing a request.
  - In S_REQ with imem_ack that same cycle → data discarded, req_addr = target, S_REQ.
  - In S_HOLD → buffer dropped, req_addr = target, S_REQ.
  - In S_DROP → pc updated to the new target, stay in S_DROP.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W (all-ones-minus-3 → 0), no error flag.
- if_opcode is combinational from if_inst. When if_valid = 0, if_inst = 0, so control_unit decodes opcode 000000 with no side effect.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - fetch_count increments by 1 on every cycle a new instruction is loaded into the output register with if_valid = 1.
  - Wraps at 2^32. Not incremented for discarded or flushed words. Cleared by rst.
- Not defined: fetch_count is tied to 0 and no counter flops exist.

Test Plan:
1. Reset with RESET_PC=0x100, imem ack every cycle → imem_addr 0x100, 0x104, 0x108 on consecutive cycles; if_pc follows one cycle later; if_valid = 1 from the first ack.
2. Stall: id_stall = 1 for 3 cycles while an ack returns word 0x8C220004 at 0x108 → word held in buffer, imem_req = 0, if_inst unchanged; after release, if_inst = 0x8C220004, if_opcode = 6'b100011.
3. Redirect with outstanding request: req to 0x200 acked 3 cycles late, branch_taken with target 0x403 asserted 1 cycle after issue → ack data discarded, if_valid = 0, next imem_addr = 0x400.
4. Same-cycle imem_ack and jump to 0x800 → fetched word discarded, next imem_addr = 0x800.
5. Simultaneous branch_taken (0x300) and jump (0x500) → next fetch at 0x300.
6. Wrap: pc = 0xFFFFFFFC, ack → if_pc_plus4 = 0, next imem_addr = 0. With FETCH_PERF_CNT_EN, after 10 delivered words and 2 flushed words, fetch_count = 10.
